// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out word assembler with a one-entry valid/ready output.
// Optional even-parity slot per frame: define PARITY_CHECK_EN.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy,
  output logic             par_err
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             busy_q;
  logic             last;
  logic             load;
  logic             drop;

  // Place the sampled bit into the word and decide frame completion
  always_comb begin
    idx  = sof ? '0 : cnt_q;
    word = sof ? '0 : sh_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CW'(LSB_FIRST ? i : WIDTH - 1 - i))
        word[i] = din;
    end
    last  = din_valid && (idx == CW'(FRAME - 1));
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (din_valid) begin
      cnt_d = last ? '0 : idx + CW'(1);
      sh_d  = last ? '0 : word;
    end
  end

  // Output register handshake and sticky overrun
  always_comb begin
    load   = last && (!vld_q || dout_ready);
    drop   = last && vld_q && !dout_ready;
    dout_d = load ? word : dout_q;
    vld_d  = vld_q;
    if (load)
      vld_d = 1'b1;
    else if (vld_q && dout_ready)
      vld_d = 1'b0;
    ovr_d = ovr_q;
    if (drop)
      ovr_d = 1'b1;
    else if (clr_ovr)
      ovr_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      busy_q <= (cnt_d != '0);
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;

  // Even parity over data plus the parity bit just sampled
  always_comb begin
    par_d = par_q;
    if (load)
      par_d = ^{word, din};
  end

  // Parity status travels with the word in dout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      par_q <= 1'b0;
    else
      par_q <= par_d;
  end

  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule
